latch_driver: RTL and testbench
===============================

# latch_driver

Clocked front-end that drives the level-sensitive D latch with active-low reset (`d`, `enable`, `reset_n`) from an asynchronous, possibly bouncing, single-bit source. It synchronizes and debounces the source. Each debounced change becomes one latch write: `d` is set up one cycle before `enable` opens, `enable` stays open for a fixed window, and `d` is held one cycle after `enable` closes. It sits directly upstream of the latch, and its outputs connect port-for-port to the latch inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a new input value must persist before it is accepted. Must be ≥1.
- `OPEN_CYCLES`, default 3: cycles `enable` stays high per write. Must be ≥1.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `din_async` input, 1 bit: raw data source, asynchronous to `clk`.
- `d` output, 1 bit, registered: data to the latch.
- `enable` output, 1 bit, registered: latch enable.
- `reset_n` output, 1 bit, registered: active-low reset to the latch; `reset_n <= ~reset`.
- `busy` output, 1 bit, registered: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`. Both reset to 0.
- **Debouncer:**
  - Holds the accepted value `deb` (reset 0) and a counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - On each edge where `s2 != deb`: `cnt` increments.
  - When that increment would make `cnt` equal DEBOUNCE_CYCLES: `deb <= s2` and `cnt <= 0`.
  - On each edge where `s2 == deb`: `cnt <= 0`. Any pulse shorter than DEBOUNCE_CYCLES cycles is therefore discarded.
- **FSM states:** IDLE, SETUP, OPEN, HOLD. Reset state is IDLE.
  - IDLE: `enable=0`. If `deb != d`, go to SETUP and load `d <= deb`; otherwise stay.
  - SETUP: 1 cycle, `enable=0`. Go to OPEN; `enable <= 1`; load the open-window counter `ocnt` (reset 0).
  - OPEN: OPEN_CYCLES cycles, `enable=1`. After the last one, go to HOLD with `enable <= 0`.
  - HOLD: 1 cycle, `enable=0`, `d` unchanged. Go to IDLE.
- `d` changes only on the IDLE→SETUP transition. It never changes while `enable=1`, or in the cycle before or after `enable=1`.
- If `deb` changes while `busy`, no pending flag is kept. IDLE re-compares `deb` against `d` on its first cycle back and starts a new write if they differ. A value that bounces back before IDLE causes no write.
- **Reset values:** `d=0`, `enable=0`, `busy=0`, `reset_n=0`, `deb=0`, FSM=IDLE.
  - `reset_n` returns to 1 on the first edge after `reset` deasserts.
  - Since `d=deb=0` after reset, no write follows reset. The latch has already been cleared by `reset_n`.
- **Reset mid-write:** on the next edge, `enable` drops to 0, `d` becomes 0, `reset_n` becomes 0, and the FSM returns to IDLE. The partial write is abandoned.

## Timing
Edge 0 is the first edge that samples the new `din_async` level, which is then held steady. N=DEBOUNCE_CYCLES, O=OPEN_CYCLES.
- `deb` updates at edge N+1.
- IDLE→SETUP and `d` update at edge N+2; `busy` rises at the same edge.
- `enable` rises at edge N+3 and falls at edge N+3+O.
- HOLD→IDLE and `busy` falls at edge N+4+O.
- Write throughput: one write per O+3 cycles at most. SETUP, OPEN and HOLD take O+2 cycles, plus at least 1 IDLE cycle.
- Without `LATCH_DRV_SYNC_EN`, every number above decreases by 2: `deb` updates at edge N-1.

## Configuration
- `LATCH_DRV_SYNC_EN`
  - Defined: the two-flop synchronizer is compiled in; the debouncer compares `s2`.
  - Undefined: `s1`/`s2` are removed and the debouncer compares `din_async` directly. The source must then already be synchronous to `clk`.

## Test plan
All scenarios use N=4, O=3, with `LATCH_DRV_SYNC_EN` defined.
- **Reset:** hold `reset=1` for 3 cycles → `d=0`, `enable=0`, `busy=0`, `reset_n=0`. Deassert → `reset_n=1` one edge later; no write occurs.
- **Clean rise:** `din_async` goes 0→1 before edge 0 →
  - `deb=1` at edge 5;
  - `d=1`, `busy=1` at edge 6;
  - `enable=1` on edges 7–9 and 0 at edge 10;
  - `busy=0` at edge 11;
  - the downstream latch `q` reads 1 afterwards.
- **Glitch reject:** a 3-cycle high pulse on `din_async` → `deb`, `d` and `enable` never change.
- **Change during busy:** 0→1 write, then `din_async`→0 accepted while in OPEN → the first write completes, then one IDLE cycle, then a second write with `d=0`.
- **Bounce-back during busy:** `deb` toggles 1→0→1 entirely within one write → no second write.
- **Mid-write reset:** assert `reset` while `enable=1` → at the next edge `enable=0`, `d=0`, `reset_n=0`, `busy=0`.

Source files
------------

// File: rtl/latch_driver.sv
// rtl/latch_driver.sv - synchronizes and debounces an async bit and turns each change into one D-latch write
// Optional macro LATCH_DRV_SYNC_EN compiles in the two-flop input synchronizer.
module latch_driver #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int OPEN_CYCLES     = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic din_async,
   output logic d,
   output logic enable,
   output logic reset_n,
   output logic busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int OW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);
   localparam logic [OW-1:0] OPEN_LOAD = OW'(OPEN_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

   logic          src;
   logic          deb;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic [OW-1:0] ocnt;
   logic [OW-1:0] ocnt_nx;
   state_t        state;
   state_t        state_nx;
   logic          d_nx;
   logic          en_nx;

`ifdef LATCH_DRV_SYNC_EN
   logic s1;
   logic s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= din_async;
         s2 <= s1;
      end
   end

   assign src = s2;
`else
   assign src = din_async;
`endif

   assign cnt_inc = cnt + 1'b1;

   // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb <= 1'b0;
         cnt <= '0;
      end else if (src != deb) begin
         if (cnt_inc == DEB_LAST) begin
            deb <= src;
            cnt <= '0;
         end else begin
            cnt <= cnt_inc;
         end
      end else begin
         cnt <= '0;
      end
   end

   always_comb begin
      state_nx = state;
      d_nx     = d;
      en_nx    = 1'b0;
      ocnt_nx  = ocnt;
      case (state)
         IDLE: begin
            if (deb != d) begin
               state_nx = SETUP;
               d_nx     = deb;
            end
         end
         SETUP: begin
            state_nx = OPEN;
            en_nx    = 1'b1;
            ocnt_nx  = OPEN_LOAD;
         end
         OPEN: begin
            if (ocnt == '0) begin
               state_nx = HOLD;
            end else begin
               en_nx   = 1'b1;
               ocnt_nx = ocnt - 1'b1;
            end
         end
         HOLD: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         d      <= 1'b0;
         enable <= 1'b0;
         busy   <= 1'b0;
         ocnt   <= '0;
      end else begin
         state  <= state_nx;
         d      <= d_nx;
         enable <= en_nx;
         busy   <= (state_nx != IDLE);
         ocnt   <= ocnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      reset_n <= ~reset;
   end

endmodule

// File: tb/tb_latch_driver.sv
// tb/tb_latch_driver.sv - directed vector bench for latch_driver (N=4, O=3, plus an O=12 instance)
module tb_latch_driver;

`ifdef LATCH_DRV_SYNC_EN
   localparam int SHIFT = 0;
`else
   localparam int SHIFT = 2;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic din;
   logic d, enable, reset_n, busy;
   logic d_l, enable_l, reset_n_l, busy_l;
   logic q;

   latch_driver #(.DEBOUNCE_CYCLES(4), .OPEN_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .din_async(din),
      .d(d), .enable(enable), .reset_n(reset_n), .busy(busy)
   );

   latch_driver #(.DEBOUNCE_CYCLES(4), .OPEN_CYCLES(12)) dut_long (
      .clk(clk), .reset(reset), .din_async(din),
      .d(d_l), .enable(enable_l), .reset_n(reset_n_l), .busy(busy_l)
   );

   // Downstream D latch with active-low reset
   always_latch begin
      if (!reset_n) q = 1'b0;
      else if (enable) q = d;
   end

   typedef struct {
      int         seq;
      int         edge_no;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;
   int   cur   = 0;

   function automatic void add(input int s, input int e, input logic [3:0] x);
      vec_t v;
      v.seq = s;
      v.edge_no = e;
      v.exp = x;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got {d,en,busy,rst_n}=%b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic go_to(input int e);
      while (cur < e - SHIFT) tick();
   endtask

   task automatic go_real(input int e);
      while (cur < e) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      din = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic run_seq(input int s);
      foreach (vecs[i]) begin
         if (vecs[i].seq == s) begin
            go_to(vecs[i].edge_no);
            check($sformatf("seq%0d_edge%0d", s, vecs[i].edge_no),
                  {d, enable, busy, reset_n}, vecs[i].exp);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   initial begin
      // seq 0: clean rise, expected {d,enable,busy,reset_n} per edge
      for (int e = 2; e <= 5; e++) add(0, e, 4'b0001);
      add(0, 6, 4'b1011);
      for (int e = 7; e <= 9; e++) add(0, e, 4'b1111);
      add(0, 10, 4'b1011);
      add(0, 11, 4'b1001);
      add(0, 12, 4'b1001);
      // seq 1: din falls while the first write is open
      add(1, 6, 4'b1011);
      for (int e = 7; e <= 9; e++) add(1, e, 4'b1111);
      add(1, 10, 4'b1011);
      add(1, 11, 4'b1001);
      add(1, 12, 4'b0011);
      for (int e = 13; e <= 15; e++) add(1, e, 4'b0111);
      add(1, 16, 4'b0011);
      add(1, 17, 4'b0001);
      add(1, 18, 4'b0001);

      reset = 1'b1;
      din = 1'b0;
      repeat (3) begin
         tick();
         check("reset_state", {d, enable, busy, reset_n}, 4'b0000);
      end
      check("reset_state_long", {d_l, enable_l, busy_l, reset_n_l}, 4'b0000);
      check("reset_q", {3'b000, q}, 4'b0000);
      reset = 1'b0;
      tick();
      check("reset_release", {d, enable, busy, reset_n}, 4'b0001);
      repeat (8) tick();
      check("no_write_after_reset", {d, enable, busy, reset_n}, 4'b0001);

      din = 1'b1;
      cur = -1;
      run_seq(0);
      check("latch_q_after_rise", {3'b000, q}, 4'b0001);

      do_reset();
      din = 1'b1;
      cur = -1;
      go_real(2);
      din = 1'b0;
      for (int e = 3; e <= 20; e++) begin
         go_real(e);
         check($sformatf("glitch_edge%0d", e), {d, enable, busy, reset_n}, 4'b0001);
      end

      do_reset();
      din = 1'b1;
      cur = -1;
      go_real(3);
      din = 1'b0;
      run_seq(1);

      // deb goes 1, 0, 1; only the long-window instance holds it within one write
      do_reset();
      din = 1'b1;
      cur = -1;
      go_real(3);
      din = 1'b0;
      go_to(6);
      check("bounce_long_start", {d_l, enable_l, busy_l, reset_n_l}, 4'b1011);
      go_real(7);
      din = 1'b1;
      go_to(12);
      check("bounce_short_second_write", {d, enable, busy, reset_n}, 4'b0011);
      go_to(13);
      check("bounce_long_open", {d_l, enable_l, busy_l, reset_n_l}, 4'b1111);
      go_to(18);
      check("bounce_short_third_write", {d, enable, busy, reset_n}, 4'b1011);
      go_to(19);
      check("bounce_long_close", {d_l, enable_l, busy_l, reset_n_l}, 4'b1011);
      for (int e = 20; e <= 30; e++) begin
         go_to(e);
         check($sformatf("bounce_long_idle_edge%0d", e),
               {d_l, enable_l, busy_l, reset_n_l}, 4'b1001);
      end

      do_reset();
      din = 1'b1;
      cur = -1;
      go_to(8);
      check("midreset_open", {d, enable, busy, reset_n}, 4'b1111);
      reset = 1'b1;
      tick();
      check("midreset_abort", {d, enable, busy, reset_n}, 4'b0000);
      check("midreset_q", {3'b000, q}, 4'b0000);
      reset = 1'b0;
      din = 1'b0;
      tick();
      check("midreset_release", {d, enable, busy, reset_n}, 4'b0001);
      repeat (10) tick();
      check("midreset_idle", {d, enable, busy, reset_n}, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
